// File: rtl/key_entry_controller.sv
// key_entry_controller: keypad consumer that builds two signed decimal operands,
// hands the selected operation to the ALU and holds the result for display.
module key_entry_controller #(
   parameter int MAX_MAG = 32767
) (
   input  logic        clk,
   input  logic        nRST,
   input  logic        read_input,
   input  logic [3:0]  keypad_input,
   input  logic [2:0]  operator_input,
   input  logic        equal_input,
   output logic        key_read,
   output logic [15:0] operand_a,
   output logic [15:0] operand_b,
   output logic [2:0]  op_code,
   output logic        calc_start,
   input  logic        calc_done,
   input  logic [15:0] calc_result,
   output logic [15:0] display_value,
   output logic        entry_ovf
);

   typedef enum logic [1:0] {
      ENTER_A,
      ENTER_B,
      CALC_WAIT,
      SHOW_RESULT
   } state_t;

   localparam logic [2:0] OP_SIGN = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_MUL  = 3'b100;

   state_t      state_q, state_d;
   logic        armed_q, armed_d;
   logic        key_read_q, key_read_d;
   logic        start_q, start_d;
   logic        ovf_q, ovf_d;
   logic [2:0]  op_q, op_d;
   logic [15:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
   logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic [15:0] result_q, result_d;

   logic        accept;
   logic [15:0] active_mag;
   logic [19:0] new_mag;
   logic [15:0] result_abs;

   function automatic logic [15:0] neg16(input logic [15:0] v);
      return ~v + 16'd1;
   endfunction

   // Operands are kept as sign + magnitude so digit entry works on the magnitude;
   // a 16-bit magnitude lets a loaded result of -32768 round-trip exactly.
   assign accept     = read_input && armed_q && (state_q != CALC_WAIT);
   assign active_mag = (state_q == ENTER_B) ? mag_b_q : mag_a_q;
   assign new_mag    = {4'b0000, active_mag} * 20'd10 + {16'h0000, keypad_input};
   assign result_abs = result_q[15] ? neg16(result_q) : result_q;

   // Next-state, handshake and datapath decisions for one key event or ALU completion
   always_comb begin
      state_d    = state_q;
      armed_d    = armed_q;
      key_read_d = accept;
      start_d    = 1'b0;
      ovf_d      = ovf_q;
      op_d       = op_q;
      mag_a_d    = mag_a_q;
      mag_b_d    = mag_b_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      result_d   = result_q;

      if (accept)
         armed_d = 1'b0;
      else if (!read_input)
         armed_d = 1'b1;

      if (state_q == CALC_WAIT && calc_done) begin
         result_d = calc_result;
         state_d  = SHOW_RESULT;
      end

      if (accept) begin
         if (equal_input) begin
            ovf_d = 1'b0;
            if (state_q == ENTER_B) begin
               start_d = 1'b1;
               state_d = CALC_WAIT;
            end
         end else if (operator_input == OP_SIGN) begin
            ovf_d = 1'b0;
            case (state_q)
               ENTER_A: sign_a_d = ~sign_a_q;
               ENTER_B: sign_b_d = ~sign_b_q;
               SHOW_RESULT: begin
                  mag_a_d  = result_abs;
                  sign_a_d = ~result_q[15];
                  state_d  = ENTER_A;
               end
               default: ;
            endcase
         end else if (operator_input >= OP_ADD && operator_input <= OP_MUL) begin
            ovf_d = 1'b0;
            op_d  = operator_input;
            if (state_q != ENTER_B) begin
               mag_b_d  = '0;
               sign_b_d = 1'b0;
               state_d  = ENTER_B;
            end
            if (state_q == SHOW_RESULT) begin
               mag_a_d  = result_abs;
               sign_a_d = result_q[15];
            end
         end else if (operator_input == 3'b000 && keypad_input <= 4'd9) begin
            if (state_q == SHOW_RESULT) begin
               mag_a_d  = {12'h000, keypad_input};
               sign_a_d = 1'b0;
               state_d  = ENTER_A;
            end else if (new_mag > 20'(MAX_MAG)) begin
               ovf_d = 1'b1;
            end else if (state_q == ENTER_B) begin
               mag_b_d = new_mag[15:0];
            end else begin
               mag_a_d = new_mag[15:0];
            end
         end
      end
   end

   // State and datapath registers with asynchronous clear
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q    <= ENTER_A;
         armed_q    <= 1'b1;
         key_read_q <= 1'b0;
         start_q    <= 1'b0;
         ovf_q      <= 1'b0;
         op_q       <= '0;
         mag_a_q    <= '0;
         mag_b_q    <= '0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         armed_q    <= armed_d;
         key_read_q <= key_read_d;
         start_q    <= start_d;
         ovf_q      <= ovf_d;
         op_q       <= op_d;
         mag_a_q    <= mag_a_d;
         mag_b_q    <= mag_b_d;
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         result_q   <= result_d;
      end
   end

   // Output mapping: signed operands and state-dependent display source
   always_comb begin
      operand_a = sign_a_q ? neg16(mag_a_q) : mag_a_q;
      operand_b = sign_b_q ? neg16(mag_b_q) : mag_b_q;
      case (state_q)
         ENTER_A: display_value = operand_a;
         ENTER_B: display_value = operand_b;
         default: display_value = result_q;
      endcase
   end

   assign key_read   = key_read_q;
   assign calc_start = start_q;
   assign op_code    = op_q;
   assign entry_ovf  = ovf_q;

endmodule
